// File: rtl/pattern_sched_pkg.sv
// Shared types and width helpers for the scheduled serial pattern matcher.
// Both the scheduler and its matcher slice import this package.
package pattern_sched_pkg;

  localparam int PAT_LEN = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SAMPLE = 3'd2,
    REPORT = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Hit map holds one bit per sample of the longest window.
  function automatic int map_w(input int win_w);
    return 1 << win_w;
  endfunction

  // One extra bit so the largest possible hit count never wraps.
  function automatic int cnt_w(input int win_w);
    return win_w + 1;
  endfunction

  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/pattern_matcher.sv
// Four-sample serial matcher: shift register, saturating fill counter and
// comparator. hit reflects the sample being shifted in this cycle.
module pattern_matcher
  import pattern_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic               sample,
  input  logic [PAT_LEN-1:0] pattern,
  output logic               hit
);

  logic [PAT_LEN-1:0] shreg;
  logic [PAT_LEN-1:0] shreg_nxt;
  logic [2:0]         fill;

  assign shreg_nxt = {shreg[PAT_LEN-2:0], sample};

  // fill counts samples already taken, so fill >= 3 means this is the 4th or later.
  assign hit = en && (fill >= 3'(PAT_LEN - 1)) && (shreg_nxt == pattern);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shreg <= '0;
      fill  <= '0;
    end else if (en) begin
      shreg <= shreg_nxt;
      if (fill != 3'(PAT_LEN)) begin
        fill <= fill + 3'd1;
      end
    end
  end

endmodule

// File: rtl/pattern_window_scheduler.sv
// Scans each enabled serial lane in turn through one shared pattern matcher
// and reports a per-lane hit map and count, then pulses done.
module pattern_window_scheduler
  import pattern_sched_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIN_W = 4
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           in,
  input  logic                       start,
  input  logic [PAT_LEN-1:0]         pattern,
  input  logic [WIN_W-1:0]           win_len,
  input  logic [LANES-1:0]           lane_mask,
  output logic                       busy,
  output logic                       done,
  output logic                       res_valid,
  output logic [lane_w(LANES)-1:0]   res_lane,
  output logic [map_w(WIN_W)-1:0]    res_map,
  output logic [cnt_w(WIN_W)-1:0]    res_count,
  output state_t                     fsm_state
);

  localparam int LW = lane_w(LANES);
  localparam int MW = map_w(WIN_W);
  localparam int CW = cnt_w(WIN_W);

  typedef logic [LW-1:0] lane_t;

  // Handshake: start is taken only while busy is low (IDLE); there is no
  // backpressure, res_valid and done are single-cycle strobes the consumer
  // must catch, and res_* stay stable until the next res_valid.

  state_t             state;
  state_t             state_nxt;

  logic [PAT_LEN-1:0] cfg_pattern;
  logic [WIN_W-1:0]   cfg_win;
  logic [LANES-1:0]   cfg_mask;

  logic               first_sel;
  lane_t              cur_lane;
  logic [WIN_W-1:0]   win_cnt;
  logic [MW-1:0]      map;
  logic [CW-1:0]      count;
  logic [MW-1:0]      map_nxt;
  logic [CW-1:0]      count_nxt;

  logic               sel_found;
  lane_t              sel_lane;
  logic               m_clear;
  logic               m_en;
  logic               hit;

  pattern_matcher u_matcher (
    .clk     (clk),
    .rst     (rst),
    .clear   (m_clear),
    .en      (m_en),
    .sample  (in[cur_lane]),
    .pattern (cfg_pattern),
    .hit     (hit)
  );

  // Next enabled lane strictly above the last scanned one (any lane on the first pick).
  always_comb begin
    sel_found = 1'b0;
    sel_lane  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!sel_found && cfg_mask[i] && (first_sel || (lane_t'(i) > cur_lane))) begin
        sel_found = 1'b1;
        sel_lane  = lane_t'(i);
      end
    end
  end

  always_comb begin
    map_nxt   = map;
    count_nxt = count;
    if (hit) begin
      map_nxt[win_cnt] = 1'b1;
      count_nxt        = count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_clear   = 1'b0;
    m_en      = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    res_valid = (state == REPORT);
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          m_clear   = 1'b1;
          state_nxt = SAMPLE;
        end else begin
          state_nxt = DONE;
        end
      end
      SAMPLE: begin
        m_en = 1'b1;
        if (win_cnt == cfg_win) begin
          state_nxt = REPORT;
        end
      end
      REPORT:  state_nxt = SELECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_pattern <= '0;
      cfg_win     <= '0;
      cfg_mask    <= '0;
      first_sel   <= 1'b0;
      cur_lane    <= '0;
      win_cnt     <= '0;
      map         <= '0;
      count       <= '0;
      res_lane    <= '0;
      res_map     <= '0;
      res_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg_pattern <= pattern;
            cfg_win     <= win_len;
            cfg_mask    <= lane_mask;
            first_sel   <= 1'b1;
          end
        end
        SELECT: begin
          if (sel_found) begin
            cur_lane  <= sel_lane;
            first_sel <= 1'b0;
            win_cnt   <= '0;
            map       <= '0;
            count     <= '0;
          end
        end
        SAMPLE: begin
          win_cnt <= win_cnt + WIN_W'(1);
          map     <= map_nxt;
          count   <= count_nxt;
          // Results land on the last sample so they are visible throughout REPORT.
          if (win_cnt == cfg_win) begin
            res_lane  <= cur_lane;
            res_map   <= map_nxt;
            res_count <= count_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_pattern_window_scheduler.sv
// Bench for pattern_window_scheduler: table vectors from known scans, hand
// sequences for abort/ignored-start cases, and randomized scans vs a model.
module tb_pattern_window_scheduler;
  import pattern_sched_pkg::*;

  localparam int W = 31;  // {report cycle[7:0], lane[1:0], map[15:0], count[4:0]}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in = '0;
  logic        start = 1'b0;
  logic [3:0]  pattern = '0;
  logic [3:0]  win_len = '0;
  logic [3:0]  lane_mask = '0;
  logic        busy;
  logic        done;
  logic        res_valid;
  logic [1:0]  res_lane;
  logic [15:0] res_map;
  logic [4:0]  res_count;
  state_t      fsm_state;

  pattern_window_scheduler #(.LANES(4), .WIN_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .start     (start),
    .pattern   (pattern),
    .win_len   (win_len),
    .lane_mask (lane_mask),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid),
    .res_lane  (res_lane),
    .res_map   (res_map),
    .res_count (res_count),
    .fsm_state (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [22:0]  last_rep = '0;
  logic [3:0]   stim [0:127];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic fill_noise(input int bias);
    for (int c = 0; c < 128; c++) begin
      for (int l = 0; l < 4; l++) begin
        stim[c][l] = ($urandom_range(0, 3) <= bias);
      end
    end
  endtask

  // Reference: lane order is ascending over the mask, slot j samples at
  // cycles j*(wl+3)+2 .. +wl, reports at (j+1)*(wl+3), done at 2+N*(wl+3).
  task automatic model_scan(input logic [3:0] pat, input logic [3:0] wl,
                            input logic [3:0] mask, output int done_c);
    int j;
    int len;
    int slot;
    j = 0;
    len = int'(wl) + 1;
    slot = int'(wl) + 3;
    for (int lane = 0; lane < 4; lane++) begin
      if (mask[lane]) begin
        logic [15:0] s;
        logic [15:0] m;
        int cnt;
        s = '0;
        m = '0;
        cnt = 0;
        for (int t = 0; t < len; t++) s[t] = stim[j*slot + 2 + t][lane];
        for (int t = 3; t < len; t++) begin
          if ({s[t-3], s[t-2], s[t-1], s[t]} == pat) begin
            m[t] = 1'b1;
            cnt++;
          end
        end
        exp_q.push_back({8'((j + 1) * slot), 2'(lane), m, 5'(cnt)});
        j++;
      end
    end
    done_c = 2 + j * slot;
  endtask

  // Drives one scan from its start cycle (c=0) and checks every cycle up to
  // two past the expected done. Config inputs are scrambled after c=0.
  task automatic run_scan(input string name, input logic [3:0] pat, input logic [3:0] wl,
                          input logic [3:0] mask, input int exp_done, input int inj_start);
    int done_c;
    int busy_bad;
    int hold_bad;
    int extra;
    logic [W-1:0] obs;
    logic [W-1:0] e;
    done_c = -1;
    busy_bad = 0;
    hold_bad = 0;
    extra = 0;
    for (int c = 0; c <= exp_done + 2; c++) begin
      @(negedge clk);
      if (busy !== ((c >= 1) && (c <= exp_done))) busy_bad++;
      if (done === 1'b1) begin
        if (done_c < 0) done_c = c;
        else extra++;
      end
      if (res_valid === 1'b1) begin
        obs = {8'(c), res_lane, res_map, res_count};
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          e = exp_q.pop_front();
          check({name, " report"}, 64'(obs), 64'(e));
          last_rep = e[22:0];
        end
      end else if ({res_lane, res_map, res_count} !== last_rep) begin
        hold_bad++;
      end
      start = (c == 0) || (c == inj_start);
      if (c == 0) begin
        pattern = pat;
        win_len = wl;
        lane_mask = mask;
      end else begin
        pattern = 4'($urandom);
        win_len = 4'($urandom);
        lane_mask = 4'($urandom);
      end
      in = stim[c];
    end
    start = 1'b0;
    check({name, " done cycle"}, 64'(done_c), 64'(exp_done));
    check({name, " busy cycles wrong"}, 64'(busy_bad), 64'd0);
    check({name, " res hold broken"}, 64'(hold_bad), 64'd0);
    check({name, " missing/extra events"}, 64'(extra + exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0]       pat;
    logic [3:0]       wl;
    logic [3:0]       mask;
    logic [3:0][15:0] seq;
    logic [1:0]       n_rep;
    logic [1:0][7:0]  rcyc;
    logic [1:0][1:0]  lane;
    logic [1:0][15:0] map;
    logic [1:0][4:0]  cnt;
    logic [7:0]       done_c;
    logic [7:0]       inj;
  } vec_t;

  vec_t tbl [6];

  task automatic set_vec(input int i, input logic [3:0] pat, input logic [3:0] wl,
                         input logic [3:0] mask, input logic [15:0] s0, input logic [15:0] s1,
                         input logic [15:0] s3, input logic [1:0] n,
                         input logic [7:0] rc0, input logic [1:0] l0, input logic [15:0] m0,
                         input logic [4:0] c0, input logic [7:0] rc1, input logic [1:0] l1,
                         input logic [15:0] m1, input logic [4:0] c1,
                         input logic [7:0] dn, input logic [7:0] inj);
    tbl[i].pat = pat;   tbl[i].wl = wl;     tbl[i].mask = mask;
    tbl[i].seq[0] = s0; tbl[i].seq[1] = s1; tbl[i].seq[2] = 16'h0; tbl[i].seq[3] = s3;
    tbl[i].n_rep = n;
    tbl[i].rcyc[0] = rc0; tbl[i].lane[0] = l0; tbl[i].map[0] = m0; tbl[i].cnt[0] = c0;
    tbl[i].rcyc[1] = rc1; tbl[i].lane[1] = l1; tbl[i].map[1] = m1; tbl[i].cnt[1] = c1;
    tbl[i].done_c = dn; tbl[i].inj = inj;
  endtask

  initial begin
    int   dn;
    int   inj;
    logic [3:0] pat;
    logic [3:0] wl;
    logic [3:0] mask;
    int   seen;

    //      idx pat   wl    mask  seq0     seq1     seq3     n  rc l  map      c   rc  l  map   c  done inj
    set_vec(0, 4'hD, 4'hF, 4'h1, 16'h005B, 16'h0,   16'h0,   1, 18, 0, 16'h0048, 2,  0, 0, 16'h0, 0, 20, 8'hFF);
    set_vec(1, 4'h5, 4'h5, 4'h0, 16'h0,    16'h0,   16'h0,   0,  0, 0, 16'h0,    0,  0, 0, 16'h0, 0,  2, 8'd1);
    set_vec(2, 4'hD, 4'h3, 4'hA, 16'h0,    16'h000B, 16'h0,  2,  6, 1, 16'h0008, 1, 12, 3, 16'h0, 0, 14, 8'd4);
    set_vec(3, 4'hF, 4'h2, 4'h1, 16'h0007, 16'h0,   16'h0,   1,  5, 0, 16'h0,    0,  0, 0, 16'h0, 0,  7, 8'hFF);
    set_vec(4, 4'hA, 4'h7, 4'h9, 16'h0055, 16'h0,   16'h000F, 2, 10, 0, 16'h00A8, 3, 20, 3, 16'h0, 0, 22, 8'd22);
    set_vec(5, 4'hF, 4'hF, 4'h1, 16'hFFFF, 16'h0,   16'h0,   1, 18, 0, 16'hFFF8, 13, 0, 0, 16'h0, 0, 20, 8'hFF);

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset res_lane", 64'(res_lane), 64'd0);
    check("reset res_map", 64'(res_map), 64'd0);
    check("reset res_count", 64'(res_count), 64'd0);
    check("reset state", 64'(fsm_state), 64'(IDLE));
    rst = 1'b0;

    // ---------------- table vectors ----------------
    for (int v = 0; v < 6; v++) begin
      int j;
      int slot;
      fill_noise($urandom_range(0, 3));
      slot = int'(tbl[v].wl) + 3;
      j = 0;
      for (int l = 0; l < 4; l++) begin
        if (tbl[v].mask[l]) begin
          for (int t = 0; t <= int'(tbl[v].wl); t++) stim[j*slot + 2 + t][l] = tbl[v].seq[l][t];
          j++;
        end
      end
      for (int r = 0; r < int'(tbl[v].n_rep); r++) begin
        exp_q.push_back({tbl[v].rcyc[r], tbl[v].lane[r], tbl[v].map[r], tbl[v].cnt[r]});
      end
      inj = (tbl[v].inj == 8'hFF) ? -1 : int'(tbl[v].inj);
      run_scan($sformatf("vec%0d", v), tbl[v].pat, tbl[v].wl, tbl[v].mask,
               int'(tbl[v].done_c), inj);
    end

    // ---------------- reset abort during SAMPLE ----------------
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 3) check("abort pre state", 64'(fsm_state), 64'(SAMPLE));
      start = (c == 0);
      pattern = 4'hF;
      win_len = 4'hF;
      lane_mask = 4'h1;
      in = 4'hF;
      rst = (c == 5);
    end
    @(negedge clk);
    check("abort outputs", 64'({busy, done, res_valid, res_lane, res_map, res_count}), 64'd0);
    check("abort state", 64'(fsm_state), 64'(IDLE));
    rst = 1'b0;
    last_rep = '0;
    @(negedge clk);
    check("post-release state", 64'(fsm_state), 64'(IDLE));
    seen = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (done || res_valid || busy) seen++;
    end
    check("abort left activity", 64'(seen), 64'd0);

    // ---------------- randomized scans ----------------
    for (int n = 0; n < 40; n++) begin
      pat = 4'($urandom);
      wl = 4'($urandom_range(0, 15));
      mask = 4'($urandom);
      fill_noise($urandom_range(0, 3));
      model_scan(pat, wl, mask, dn);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, dn) : -1;
      run_scan($sformatf("rand%0d", n), pat, wl, mask, dn, inj);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
